// File: rtl/fft_pkg.sv
// Shared types and constants for the pipelined FFT stages.
// Q15.8 data and Q.8 twiddles.
package fft_pkg;
  localparam int DATA_W = 24;
  localparam int FRAC   = 8;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_BF   = 2'd1,
    ST_TW   = 2'd2,
    ST_ILL  = 2'd3
  } st_e;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;
endpackage

// File: rtl/fft_cmul_q8.sv
// Combinational complex multiply, y = (a*b) >>> FRAC with floor rounding and DATA_W wrap.
// Zero latency, no flow control.
module fft_cmul_q8
  import fft_pkg::*;
(
  input  cplx_t a_i,
  input  cplx_t b_i,
  output cplx_t y_o
);
  localparam int PW = 2 * DATA_W + 1;

  logic signed [PW-1:0] ar, ai, br, bi;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;

  // One guard bit above the full product width keeps the sum/difference exact.
  assign ar = {{(DATA_W+1){a_i.re[DATA_W-1]}}, a_i.re};
  assign ai = {{(DATA_W+1){a_i.im[DATA_W-1]}}, a_i.im};
  assign br = {{(DATA_W+1){b_i.re[DATA_W-1]}}, b_i.re};
  assign bi = {{(DATA_W+1){b_i.im[DATA_W-1]}}, b_i.im};

  assign p_rr = ar * br;
  assign p_ii = ai * bi;
  assign p_ri = ar * bi;
  assign p_ir = ai * br;

  assign y_o.re = DATA_W'((p_rr - p_ii) >>> FRAC);
  assign y_o.im = DATA_W'((p_ri + p_ir) >>> FRAC);
endmodule

// File: rtl/fft_sdf_bf_d4.sv
// Radix-2 SDF butterfly with DEPTH-sample feedback line; one-cycle registered output.
// No backpressure: one sample consumed per active cycle, state 3 freezes the stage.
module fft_sdf_bf_d4
  import fft_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] din_r,
  input  logic signed [DATA_W-1:0] din_i,
  input  logic [1:0]               state,
  input  logic signed [DATA_W-1:0] w_r,
  input  logic signed [DATA_W-1:0] w_i,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] dout_r,
  output logic signed [DATA_W-1:0] dout_i
);
  st_e   st;
  cplx_t dl_q [DEPTH];
  cplx_t dl_d [DEPTH];
  cplx_t dout_q, dout_d;
  logic  out_valid_q, out_valid_d;
  cplx_t x, h, sum, dif, tw, push, w;
  logic  active;

  assign st = st_e'(state);
  assign w  = '{re: w_r, im: w_i};
  assign h  = dl_q[0];

  fft_cmul_q8 u_cmul (
    .a_i (h),
    .b_i (w),
    .y_o (tw)
  );

  always_comb begin
    x = '0;
    if (in_valid) x = '{re: din_r, im: din_i};

    sum.re = h.re + x.re;
    sum.im = h.im + x.im;
    dif.re = h.re - x.re;
    dif.im = h.im - x.im;
    push   = (st == ST_BF) ? dif : x;

    // Flush cycles (state 1/2 without input) still advance the line with x = 0.
    active = (st != ST_ILL) && (in_valid || st == ST_BF || st == ST_TW);

    dl_d = dl_q;
    if (active) begin
      for (int i = 0; i < DEPTH - 1; i++) dl_d[i] = dl_q[i+1];
      dl_d[DEPTH-1] = push;
    end

    out_valid_d = active && (st == ST_BF || st == ST_TW);
    dout_d      = dout_q;
    if (out_valid_d) dout_d = (st == ST_BF) ? sum : tw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) dl_q[i] <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) dl_q[i] <= dl_d[i];
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout_r    = dout_q.re;
  assign dout_i    = dout_q.im;
endmodule

// File: tb/tb_fft_sdf_bf_d4.sv
// Randomised and directed bench for fft_sdf_bf_d4 against a queue-based behavioural model.
module tb_fft_sdf_bf_d4;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [23:0] din_r = '0, din_i = '0, w_r = '0, w_i = '0;
  logic [1:0]  state = '0;
  logic        out_valid;
  logic [23:0] dout_r, dout_i;

  int checks = 0;
  int errors = 0;

  int q_r[$], q_i[$];
  int exp_r, exp_i;
  bit exp_vld;

  fft_sdf_bf_d4 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .din_r     (din_r),
    .din_i     (din_i),
    .state     (state),
    .w_r       (w_r),
    .w_i       (w_i),
    .out_valid (out_valid),
    .dout_r    (dout_r),
    .dout_i    (dout_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int w24(input longint v);
    logic [23:0] t;
    t = v[23:0];
    return int'($signed(t));
  endfunction

  function automatic logic [47:0] pk(input int r, input int i);
    logic [23:0] a, b;
    a = r[23:0];
    b = i[23:0];
    return {a, b};
  endfunction

  task automatic model_reset();
    q_r.delete();
    q_i.delete();
    for (int k = 0; k < 4; k++) begin
      q_r.push_back(0);
      q_i.push_back(0);
    end
    exp_r = 0;
    exp_i = 0;
    exp_vld = 0;
  endtask

  task automatic model_step(input bit v, input int dr, input int di, input int st,
                            input int wr, input int wi);
    int xr, xi, hr, hi;
    bit act;
    longint pr, pi;
    act = (st != 3) && (v || st == 1 || st == 2);
    exp_vld = act && (st == 1 || st == 2);
    if (act) begin
      xr = v ? dr : 0;
      xi = v ? di : 0;
      hr = q_r.pop_front();
      hi = q_i.pop_front();
      if (st == 1) begin
        exp_r = w24(longint'(hr) + xr);
        exp_i = w24(longint'(hi) + xi);
        q_r.push_back(w24(longint'(hr) - xr));
        q_i.push_back(w24(longint'(hi) - xi));
      end else begin
        if (st == 2) begin
          pr = longint'(hr) * wr - longint'(hi) * wi;
          pi = longint'(hr) * wi + longint'(hi) * wr;
          exp_r = w24(pr >>> 8);
          exp_i = w24(pi >>> 8);
        end
        q_r.push_back(xr);
        q_i.push_back(xi);
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model, check outputs 1 time unit after the edge.
  task automatic step(input bit v, input int dr, input int di, input int st,
                      input int wr, input int wi);
    in_valid = v;
    din_r = dr[23:0];
    din_i = di[23:0];
    state = st[1:0];
    w_r = wr[23:0];
    w_i = wi[23:0];
    model_step(v, dr, di, st, wr, wi);
    @(posedge clk);
    #1;
    chk("out_valid", {47'd0, out_valid}, {47'd0, exp_vld});
    chk("dout", {dout_r, dout_i}, pk(exp_r, exp_i));
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    model_reset();
    for (int k = 0; k < cycles; k++) begin
      in_valid = 1'($urandom);
      din_r = 24'($urandom);
      din_i = 24'($urandom);
      state = 2'($urandom);
      w_r = 24'($urandom);
      w_i = 24'($urandom);
      @(posedge clk);
      #1;
      chk("rst_vld", {47'd0, out_valid}, 48'd0);
      chk("rst_dout", {dout_r, dout_i}, 48'd0);
    end
    rst_n = 1'b1;
  endtask

  int ramp_tw_r[4] = '{256, 362, 0, -724};
  int ramp_tw_i[4] = '{0, -362, -768, -724};
  int ramp_w_r[4]  = '{256, 181, 0, -181};
  int ramp_w_i[4]  = '{0, -181, -256, -181};

  initial begin
    #1;
    do_reset(5);

    // DC frame
    for (int k = 0; k < 4; k++) step(1, 256, 0, 0, 256, 0);
    for (int k = 0; k < 4; k++) begin
      step(1, 256, 0, 1, 256, 0);
      chk("dc_bf", {dout_r, dout_i}, pk(512, 0));
    end
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 2, 256, 0);
      chk("dc_tw", {dout_r, dout_i}, pk(0, 0));
    end

    // Ramp / twiddle
    for (int k = 0; k < 4; k++) step(1, 256 * (k + 1), 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 0, 1, 0, 0);
      chk("ramp_bf", {dout_r, dout_i}, pk(256 * (k + 1), 0));
    end
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 2, ramp_w_r[k], ramp_w_i[k]);
      chk("ramp_tw", {dout_r, dout_i}, pk(ramp_tw_r[k], ramp_tw_i[k]));
    end

    // Floor rounding on a negative head
    for (int k = 0; k < 4; k++) step(1, -1, 0, 0, 0, 0);
    step(0, 0, 0, 2, 181, -181);
    chk("round", {dout_r, dout_i}, {24'hFFFFFF, 24'h000000});
    for (int k = 0; k < 3; k++) step(0, 0, 0, 2, 256, 0);

    // Two's-complement wrap in the butterfly
    for (int k = 0; k < 4; k++) step(1, 24'h7FFFFF, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0, 0);
    chk("wrap_sum", {dout_r, dout_i}, {24'h800000, 24'h000000});
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 2, 256, 0);
    chk("wrap_dif", {dout_r, dout_i}, {24'h7FFFFE, 24'h000000});
    for (int k = 0; k < 3; k++) step(0, 0, 0, 2, 256, 0);

    // Illegal gaps mid-frame, including one with in_valid high
    for (int k = 0; k < 4; k++) step(1, 100 * (k + 1), -50 * k, 0, 0, 0);
    step(1, 10, 20, 1, 0, 0);
    step(1, 999, 999, 3, 0, 0);
    chk("ill_vld", {47'd0, out_valid}, 48'd0);
    step(0, 0, 0, 3, 0, 0);
    for (int k = 0; k < 3; k++) step(1, 7 * k, 3, 1, 0, 0);
    for (int k = 0; k < 2; k++) step(0, 0, 0, 2, 181, -181);
    step(0, 0, 0, 3, 0, 0);
    for (int k = 0; k < 2; k++) step(0, 0, 0, 2, 181, 181);

    // Asynchronous reset pulse during butterfly
    for (int k = 0; k < 4; k++) step(1, 5000 + k, -3000, 0, 0, 0);
    step(1, 1, 1, 1, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_vld", {47'd0, out_valid}, 48'd0);
    chk("arst_dout", {dout_r, dout_i}, 48'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 1, 0, 0);
      chk("arst_line", {dout_r, dout_i}, 48'd0);
    end

    // Random traffic, mostly generator-like phases with occasional illegal/idle cycles
    for (int k = 0; k < 1500; k++) begin
      int st;
      st = (($urandom % 16) == 0) ? 3 : ((k / 4) % 3 == 0 ? 0 : ((k / 4) % 3 == 1 ? 1 : 2));
      step(1'($urandom), int'($signed(24'($urandom))), int'($signed(24'($urandom))), st,
           int'($signed(24'($urandom))), int'($signed(24'($urandom))));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
